// File: rtl/m_axil_master_if.sv
// m_axil_master_if: AXI4-Lite bus between one initiator (master) and one register slave (slave).
interface m_axil_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();
  logic [ADDR_WIDTH+1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH+1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/m_axil_master.sv
// m_axil_master: AXI4-Lite initiator, one command in flight, results returned on a valid/ready response port.
// Defining AXIL_TIMEOUT_EN bounds the B/R wait to TIMEOUT_CYCLES and then reports rsp_resp=2'b11.
module m_axil_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH+1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  m_axil_master_if.master         m_axil
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP, RSP} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              resp_q, resp_d;
`ifdef AXIL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
    $error("m_axil_master: unsupported parameter values");
  end
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_ready_d = 1'b0;
        addr_d      = cmd_addr;
        wdata_d     = cmd_wdata;
        wstrb_d     = cmd_wstrb;
        awvalid_d   = cmd_write;
        wvalid_d    = cmd_write;
        arvalid_d   = !cmd_write;
        state_d     = cmd_write ? WR : RD;
      end
      WR: begin
        // AW and W complete independently; B is only awaited once both are gone.
        awvalid_d = awvalid_q && !m_axil.awready;
        wvalid_d  = wvalid_q && !m_axil.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: if (m_axil.bvalid) begin
        bready_d    = 1'b0;
        resp_d      = m_axil.bresp;
        rdata_d     = '0;
        rsp_write_d = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RD: if (m_axil.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RRESP;
      end
      RRESP: if (m_axil.rvalid) begin
        rready_d    = 1'b0;
        resp_d      = m_axil.rresp;
        rdata_d     = m_axil.rdata;
        rsp_write_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef AXIL_TIMEOUT_EN
    if ((state_q == WRESP || state_q == RRESP) && state_d == state_q && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      resp_d      = 2'b11;
      rdata_d     = '0;
      rsp_write_d = state_q == WRESP;
      rsp_valid_d = 1'b1;
      state_d     = RSP;
    end
    cnt_d = (state_d == state_q && (state_q == WRESP || state_q == RRESP)) ? cnt_q + 16'd1 : '0;
`endif
  end
  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
`ifdef AXIL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
`ifdef AXIL_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;
endmodule
